// File: rtl/dram_request_arbiter.sv
// Round-robin arbiter sharing one dram cache-line port among NUM_REQ clients.
// Define DRAM_ARB_PRIO0_EN to give client 0 strict priority over the rest.
module dram_request_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 27,
  parameter int DATA_BITS = 512
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_data,
  input  logic                           dram_read_rdy,
  input  logic                           dram_write_rdy,
  output logic                           dram_read_rq,
  output logic                           dram_write_rq,
  output logic [ADDR_BITS-1:0]           dram_addr,
  output logic [DATA_BITS-1:0]           dram_wdata,
  input  logic                           dram_read_valid,
  input  logic [DATA_BITS-1:0]           dram_read_data
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_e;

  state_e                 state_q;
  logic [IW-1:0]          rr_q;
  logic [IW-1:0]          grant_q;
  logic                   we_q;
  logic [NUM_REQ-1:0]     ack_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_BITS-1:0]   rsp_data_q;
  logic                   rd_rq_q;
  logic                   wr_rq_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-1:0]   wdata_q;

  logic [NUM_REQ-1:0]     elig;
  logic                   found_d;
  logic [IW-1:0]          pick_d;
  logic                   upd_rr_d;
  logic [IW-1:0]          idx;
  int                     j;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] &
                (req_we[i] ? dram_write_rdy : dram_read_rdy);
    end
  end

  // Scan rr_q+1, rr_q+2, ... wrapping; first eligible wins.
  always_comb begin
    found_d  = 1'b0;
    pick_d   = '0;
    upd_rr_d = 1'b1;
    j        = 0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IW'(j);
      if (!found_d && elig[idx]) begin
        found_d = 1'b1;
        pick_d  = idx;
      end
    end
`ifdef DRAM_ARB_PRIO0_EN
    if (elig[0]) begin
      pick_d   = '0;
      upd_rr_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_REQ - 1);
      grant_q     <= '0;
      we_q        <= 1'b0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rd_rq_q     <= 1'b0;
      wr_rq_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rd_rq_q     <= 1'b0;
      wr_rq_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= pick_d;
            we_q    <= req_we[pick_d];
            addr_q  <= req_addr[int'(pick_d)*ADDR_BITS +: ADDR_BITS];
            if (req_we[pick_d]) begin
              wdata_q <= req_wdata[int'(pick_d)*DATA_BITS +: DATA_BITS];
            end
            if (upd_rr_d) rr_q <= pick_d;
            ack_q[pick_d] <= 1'b1;
            rd_rq_q <= ~req_we[pick_d];
            wr_rq_q <= req_we[pick_d];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= we_q ? IDLE : WAIT_RD;
        end
        WAIT_RD: begin
          if (dram_read_valid) begin
            rsp_data_q           <= dram_read_data;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ack       = ack_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign dram_read_rq  = rd_rq_q;
  assign dram_write_rq = wr_rq_q;
  assign dram_addr     = addr_q;
  assign dram_wdata    = wdata_q;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: vector table plus corner sequences.
// Expectations follow DRAM_ARB_PRIO0_EN when it is defined for the build.
module tb_dram_request_arbiter;

  localparam int N  = 2;
  localparam int AW = 27;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            dram_read_rdy = 1'b1;
  logic            dram_write_rdy = 1'b1;
  logic            dram_read_rq;
  logic            dram_write_rq;
  logic [AW-1:0]   dram_addr;
  logic [DW-1:0]   dram_wdata;
  logic            dram_read_valid = 1'b0;
  logic [DW-1:0]   dram_read_data = '0;

  dram_request_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dram_read_rdy(dram_read_rdy), .dram_write_rdy(dram_write_rdy),
    .dram_read_rq(dram_read_rq), .dram_write_rq(dram_write_rq),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_read_valid(dram_read_valid), .dram_read_data(dram_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic       rrdy;
    logic       wrdy;
    logic [1:0] ack_rr;
    logic [1:0] ack_p0;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic cyc_drop();
    @(negedge clk);
    req_valid = req_valid & ~req_ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    dram_read_rdy = 1'b1;
    dram_write_rdy = 1'b1;
    dram_read_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0]    ea;
  logic          erd;
  logic          ewr;
  logic [1:0]    first_g;
  logic [1:0]    second_g;
  logic [1:0]    alt_exp;
  logic          quiet;
  logic [DW-1:0] pat;
  int            n;

  initial begin
    vt[0] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b01};
    vt[1] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01};
    vt[2] = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00};
    vt[3] = '{2'b11, 2'b01, 1'b0, 1'b1, 2'b01, 2'b01};
    vt[4] = '{2'b11, 2'b10, 1'b0, 1'b1, 2'b10, 2'b10};
    vt[5] = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01};
    vt[6] = '{2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10};
    vt[7] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b01};
    vt[8] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00};
    vt[9] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 2'b01};

    // Idle after reset: nothing moves for 20 cycles.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk($sformatf("idle_outs_c%0d", c),
          DW'({req_ack, rsp_valid, dram_read_rq, dram_write_rq, dram_addr}),
          '0);
    end
    chk("idle_rsp_data", rsp_data, '0);
    chk("idle_wdata", dram_wdata, '0);

    // Arbitration table, each vector applied from IDLE.
    do_reset();
    for (int k = 0; k < 10; k++) begin
`ifdef DRAM_ARB_PRIO0_EN
      ea = vt[k].ack_p0;
`else
      ea = vt[k].ack_rr;
`endif
      req_valid = vt[k].valid;
      req_we = vt[k].we;
      dram_read_rdy = vt[k].rrdy;
      dram_write_rdy = vt[k].wrdy;
      req_addr[0 +: AW] = AW'(32'h100 + k);
      req_addr[AW +: AW] = AW'(32'h200 + k);
      req_wdata[0 +: DW] = DW'(32'h5000 + k);
      req_wdata[DW +: DW] = DW'(32'h6000 + k);
      ewr = |(ea & vt[k].we);
      erd = (ea != 2'b00) && !ewr;
      cyc();
      chk($sformatf("vec%0d_ack", k), DW'(req_ack), DW'(ea));
      chk($sformatf("vec%0d_rq", k), DW'({dram_read_rq, dram_write_rq}),
          DW'({erd, ewr}));
      if (ea != 2'b00) begin
        chk($sformatf("vec%0d_addr", k), DW'(dram_addr),
            DW'(ea[1] ? 32'h200 + k : 32'h100 + k));
      end
      if (ewr) begin
        chk($sformatf("vec%0d_wdata", k), dram_wdata,
            DW'(ea[1] ? 32'h6000 + k : 32'h5000 + k));
      end
      req_valid = '0;
      dram_read_rdy = 1'b1;
      dram_write_rdy = 1'b1;
      if (erd) begin
        cyc();
        dram_read_valid = 1'b1;
        dram_read_data = DW'(32'h7700 + k);
        cyc();
        dram_read_valid = 1'b0;
        chk($sformatf("vec%0d_rsp_valid", k), DW'(rsp_valid), DW'(ea));
        chk($sformatf("vec%0d_rsp_data", k), rsp_data, DW'(32'h7700 + k));
      end
      cyc();
    end

    // Client 1 read with 10-cycle dram latency.
    pat = {64{8'hA5}};
    req_valid = 2'b10;
    req_we = 2'b00;
    req_addr[AW +: AW] = 27'h0000123;
    cyc_drop();
    chk("rd_ack", DW'(req_ack), DW'(2'b10));
    chk("rd_rq", DW'({dram_read_rq, dram_write_rq}), DW'(2'b10));
    chk("rd_addr", DW'(dram_addr), DW'(27'h123));
    quiet = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cyc();
      if (rsp_valid != 2'b00 || req_ack != 2'b00 || dram_read_rq) quiet = 1'b0;
    end
    chk("rd_wait_quiet", DW'(quiet), DW'(1'b1));
    dram_read_valid = 1'b1;
    dram_read_data = pat;
    cyc();
    dram_read_valid = 1'b0;
    dram_read_data = '0;
    chk("rd_rsp_valid", DW'(rsp_valid), DW'(2'b10));
    chk("rd_rsp_data", rsp_data, pat);
    cyc();
    chk("rd_rsp_pulse", DW'(rsp_valid), DW'(2'b00));

    // Simultaneous writes, pointer at 1: order 0 then 1.
    req_valid = 2'b11;
    req_we = 2'b11;
    req_wdata[0 +: DW] = DW'(32'h11);
    req_wdata[DW +: DW] = DW'(32'h22);
    cyc_drop();
    chk("wr1_ack_a", DW'(req_ack), DW'(2'b01));
    chk("wr1_wdata_a", dram_wdata, DW'(32'h11));
    chk("wr1_wrq_a", DW'(dram_write_rq), DW'(1'b1));
    cyc_drop();
    chk("wr1_gap", DW'({req_ack, dram_write_rq}), '0);
    cyc_drop();
    chk("wr1_ack_b", DW'(req_ack), DW'(2'b10));
    chk("wr1_wdata_b", dram_wdata, DW'(32'h22));
    chk("wr1_wrq_b", DW'(dram_write_rq), DW'(1'b1));
    cyc();

    // Lone client 0 write moves the pointer to 0 (round-robin build).
    req_valid = 2'b01;
    cyc_drop();
    chk("wr_solo_ack", DW'(req_ack), DW'(2'b01));
    cyc();
`ifdef DRAM_ARB_PRIO0_EN
    first_g = 2'b01;
    second_g = 2'b10;
`else
    first_g = 2'b10;
    second_g = 2'b01;
`endif
    req_valid = 2'b11;
    cyc_drop();
    chk("wr2_ack_a", DW'(req_ack), DW'(first_g));
    chk("wr2_wdata_a", dram_wdata, DW'(first_g[1] ? 32'h22 : 32'h11));
    cyc_drop();
    chk("wr2_gap", DW'({req_ack, dram_write_rq}), '0);
    cyc_drop();
    chk("wr2_ack_b", DW'(req_ack), DW'(second_g));
    chk("wr2_wdata_b", dram_wdata, DW'(second_g[1] ? 32'h22 : 32'h11));
    cyc();

    // Reset while waiting for read data; late response must be dropped.
    req_valid = 2'b01;
    req_we = 2'b00;
    cyc_drop();
    chk("rst_rd_ack", DW'(req_ack), DW'(2'b01));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    dram_read_valid = 1'b1;
    dram_read_data = pat;
    cyc();
    dram_read_valid = 1'b0;
    chk("rst_stale_valid", DW'(rsp_valid), DW'(2'b00));
    chk("rst_stale_data", rsp_data, '0);
    cyc();
    chk("rst_stale_valid2", DW'(rsp_valid), DW'(2'b00));
    req_valid = 2'b10;
    req_we = 2'b10;
    cyc_drop();
    chk("rst_new_ack", DW'(req_ack), DW'(2'b10));
    chk("rst_new_wrq", DW'(dram_write_rq), DW'(1'b1));
    cyc();

    // Both clients hold requests continuously.
    do_reset();
    req_valid = 2'b11;
    req_we = 2'b11;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      cyc();
      if (req_ack != 2'b00) begin
`ifdef DRAM_ARB_PRIO0_EN
        alt_exp = 2'b01;
`else
        alt_exp = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
        chk($sformatf("cont_grant%0d", n), DW'(req_ack), DW'(alt_exp));
        n++;
      end
    end
    chk("cont_grant_count", DW'(n), DW'(4));
    req_valid = '0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
